// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
//   Shared types and helpers for the round-robin bus arbiter.
//   - arb_state_e      : arbiter FSM states (IDLE, GRANT)
//   - DEFAULT_MAX_HOLD : default forced-release limit for ARB_HOLD_LIMIT_EN builds
//   - clog2_min1()     : ceil(log2(n)) clamped to at least 1, used for index widths
// -----------------------------------------------------------------------------
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int DEFAULT_MAX_HOLD = 16;

    // Width needed to hold an index in [0, n-1]; never zero so that a single
    // master still gets a real (1-bit) gnt_id port.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker. Returns the first set request bit at or
//   above ptr, wrapping modulo N, optionally ignoring one excluded master.
//   Ports:
//     req      in  [N-1:0]     request vector
//     ptr      in  [ID_W-1:0]  highest-priority index
//     excl_en  in              enable exclusion of excl_idx
//     excl_idx in  [ID_W-1:0]  master to ignore (the current owner)
//     found    out             at least one eligible request
//     idx      out [ID_W-1:0]  index of the winner (0 when found=0)
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    input  logic            excl_en,
    input  logic [ID_W-1:0] excl_idx,
    output logic            found,
    output logic [ID_W-1:0] idx
);

    localparam int W2 = 2 * N;

    logic [N-1:0]  excl_hit;
    logic [N-1:0]  req_m;
    logic [W2-1:0] dbl;
    logic [W2-1:0] above;
    int            sel;

    genvar gi;

    generate
        for (gi = 0; gi < N; gi++) begin : g_excl
            assign excl_hit[gi] = excl_en && (int'(excl_idx) == gi);
        end
    endgenerate

    assign req_m = req & ~excl_hit;

    // Two copies side by side: masking off everything below ptr in the
    // doubled vector leaves the wrapped-around bits in the upper copy, so a
    // plain lowest-bit search yields the round-robin winner.
    assign dbl = {req_m, req_m};

    generate
        for (gi = 0; gi < W2; gi++) begin : g_mask
            assign above[gi] = dbl[gi] && (gi >= int'(ptr));
        end
    endgenerate

    always_comb begin
        found = 1'b0;
        sel   = 0;
        for (int i = W2 - 1; i >= 0; i--) begin
            if (above[i]) begin
                found = 1'b1;
                sel   = i;
            end
        end
        idx = (sel >= N) ? ID_W'(sel - N) : ID_W'(sel);
    end

endmodule

// File: rtl/rr_bus_arbiter.sv
// -----------------------------------------------------------------------------
// rr_bus_arbiter
//   N-master round-robin bus arbiter with registered one-hot grants and bus
//   locking: an owner keeps the bus for as long as it holds its request.
//   Optional feature macro: ARB_HOLD_LIMIT_EN -- when defined, an owner that
//   has held the bus MAX_HOLD cycles is forced off if anyone else is waiting,
//   and preempt pulses for one cycle.
//   Ports:
//     clk        in               system clock, rising edge
//     rst        in               synchronous active-high reset
//     req        in  [N-1:0]      per-master request, held for the transaction
//     gnt        out [N-1:0]      registered one-hot grant, zero when idle
//     gnt_id     out [ID_W-1:0]   binary index of the granted master
//     gnt_valid  out              |gnt
//     preempt    out              1-cycle forced-release pulse (0 if feature off)
// -----------------------------------------------------------------------------
module rr_bus_arbiter
    import arb_pkg::*;
#(
    parameter  int NUM_MASTERS = 4,
    parameter  int MAX_HOLD    = DEFAULT_MAX_HOLD,
    localparam int ID_W        = clog2_min1(NUM_MASTERS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] req,
    output logic [NUM_MASTERS-1:0] gnt,
    output logic [ID_W-1:0]        gnt_id,
    output logic                   gnt_valid,
    output logic                   preempt
);

    generate
        if (NUM_MASTERS < 1 || MAX_HOLD < 2) begin : g_bad_cfg
            $error("rr_bus_arbiter: NUM_MASTERS must be >=1 and MAX_HOLD >=2");
        end
    endgenerate

    arb_state_e             state_q, state_d;
    logic [ID_W-1:0]        ptr_q, ptr_d;
    logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]        gnt_id_q, gnt_id_d;

    logic                   pick_found;
    logic [ID_W-1:0]        pick_idx;
    logic [ID_W-1:0]        pick_next_ptr;
    logic                   owner_req;
    logic                   force_release;
    logic                   take_pick;
    logic                   go_idle;

    assign owner_req = req[gnt_id_q];

    // In GRANT the owner is excluded, so pick_found means "someone else waits".
    rr_pick #(
        .N    (NUM_MASTERS),
        .ID_W (ID_W)
    ) u_pick (
        .req      (req),
        .ptr      (ptr_q),
        .excl_en  (state_q == GRANT),
        .excl_idx (gnt_id_q),
        .found    (pick_found),
        .idx      (pick_idx)
    );

    assign pick_next_ptr = (pick_idx == ID_W'(NUM_MASTERS - 1)) ? '0 : pick_idx + 1'b1;

`ifdef ARB_HOLD_LIMIT_EN
    localparam int HC_W = clog2_min1(MAX_HOLD);

    logic [HC_W-1:0] hold_cnt_q, hold_cnt_d;
    logic            preempt_q, preempt_d;

    assign force_release = (state_q == GRANT) && owner_req && pick_found
                           && (hold_cnt_q == HC_W'(MAX_HOLD - 1));

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        preempt_d  = 1'b0;
        if (take_pick || go_idle) begin
            hold_cnt_d = '0;
            preempt_d  = force_release;
        end else if (state_q == GRANT && hold_cnt_q != HC_W'(MAX_HOLD - 1)) begin
            // Saturates when nobody else is waiting and the owner stays on.
            hold_cnt_d = hold_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_q <= '0;
            preempt_q  <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            preempt_q  <= preempt_d;
        end
    end

    assign preempt = preempt_q;
`else
    assign force_release = 1'b0;
    assign preempt       = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        take_pick = 1'b0;
        go_idle   = 1'b0;

        case (state_q)
            IDLE: begin
                take_pick = pick_found;
            end
            GRANT: begin
                // Lock: other requests are ignored while the owner holds req.
                if (!owner_req || force_release) begin
                    take_pick = pick_found;
                    go_idle   = !pick_found;
                end
            end
            default: begin
                go_idle = 1'b1;
            end
        endcase

        if (take_pick) begin
            state_d  = GRANT;
            gnt_d    = NUM_MASTERS'(1) << pick_idx;
            gnt_id_d = pick_idx;
            ptr_d    = pick_next_ptr;
        end else if (go_idle) begin
            state_d  = IDLE;
            gnt_d    = '0;
            gnt_id_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            gnt_q    <= '0;
            gnt_id_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = |gnt_q;

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_bus_arbiter
//   Directed testbench for rr_bus_arbiter (NUM_MASTERS=4, MAX_HOLD=4).
//   Covers reset, rotation, lock, idle/latency, wrap-around, reset mid-grant
//   and the hold-limit behaviour (ARB_HOLD_LIMIT_EN on or off).
// -----------------------------------------------------------------------------
module tb_rr_bus_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       preempt;

    int n_checks;
    int n_errors;

    rr_bus_arbiter #(
        .NUM_MASTERS (4),
        .MAX_HOLD    (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Grant snapshot: gnt, gnt_id and gnt_valid against one expected owner
    // (owner < 0 means idle).
    task automatic check_gnt(input string tag, input int owner);
        if (owner < 0) begin
            check({tag, ".gnt"},   32'(gnt), 32'h0);
            check({tag, ".valid"}, 32'(gnt_valid), 32'h0);
        end else begin
            check({tag, ".gnt"},   32'(gnt), 32'(1 << owner));
            check({tag, ".id"},    32'(gnt_id), 32'(owner));
            check({tag, ".valid"}, 32'(gnt_valid), 32'h1);
        end
    endtask

    initial begin
        int owner;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        req = 4'b1111;

        // Reset held 3 cycles with every request up.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst.gnt",     32'(gnt), 32'h0);
            check("rst.id",      32'(gnt_id), 32'h0);
            check("rst.valid",   32'(gnt_valid), 32'h0);
            check("rst.preempt", 32'(preempt), 32'h0);
        end
        rst = 1'b0;
        tick();
        check_gnt("first", 0);

        // Rotation: each owner drops its req for one cycle after two cycles.
        owner = 0;
        for (int k = 0; k < 4; k++) begin
            req = 4'b1111;
            tick();
            check_gnt("rot.hold", owner);
            req = 4'b1111 & ~(4'(1) << owner);
            tick();
            owner = (owner + 1) % 4;
            check_gnt("rot.next", owner);
        end
        req = 4'b0000;
        tick();
        check_gnt("rot.idle", -1);

        // Lock: m1 keeps the bus while req[0] waits; ptr is 1 here.
        req = 4'b0010;
        tick();
        check_gnt("lock.m1", 1);
        req = 4'b0011;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("lock.held", 32'(gnt), 32'h2);
        end
        req = 4'b0001;
        tick();
        check_gnt("lock.m0", 0);
        req = 4'b0000;
        tick();
        check_gnt("lock.idle", -1);

        // Idle/latency: 3-cycle req[2] pulse, gnt[2] on cycles 2..4.
        req = 4'b0100;
        #1;
        check("lat.c1", 32'(gnt), 32'h0);
        tick();
        check_gnt("lat.c2", 2);
        tick();
        check_gnt("lat.c3", 2);
        tick();
        check_gnt("lat.c4", 2);
        req = 4'b0000;
        tick();
        check_gnt("lat.c5", -1);
        tick();
        check_gnt("lat.c6", -1);

        // Wrap: ptr=3 after m2, so m3 beats m0.
        req = 4'b1001;
        tick();
        check_gnt("wrap.m3", 3);
        req = 4'b0001;
        tick();
        check_gnt("wrap.m0", 0);

        // Reset mid-grant drops gnt on the next edge; ptr returns to 0.
        req = 4'b0011;
        rst = 1'b1;
        tick();
        check_gnt("midrst", -1);
        rst = 1'b0;
        tick();
        check_gnt("hold.m0", 0);

`ifdef ARB_HOLD_LIMIT_EN
        // MAX_HOLD=4: m0 owns 4 cycles, m1 4 cycles, then m0 again.
        for (int c = 2; c <= 9; c++) begin
            tick();
            check("hold.gnt", 32'(gnt), (c <= 4 || c >= 9) ? 32'h1 : 32'h2);
            check("hold.preempt", 32'(preempt), (c == 5 || c == 9) ? 32'h1 : 32'h0);
        end
`else
        // Unbounded lock: m0 keeps the bus while req[0] stays high.
        for (int c = 0; c < 20; c++) begin
            tick();
            check("hold.gnt", 32'(gnt), 32'h1);
            check("hold.preempt", 32'(preempt), 32'h0);
        end
`endif

        req = 4'b0000;
        tick();
        check_gnt("end.idle", -1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
